fifo_burst_reader: RTL and testbench
====================================

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 Parameter BURST_LEN, default 500, words per burst; legal range 2..ALMOST_EMPTY_OFFSET of the feeding FIFO.
REQ-002 Ports are listed below as name, direction, width, meaning; there is one clock and reset is synchronous and active-high.
REQ-003 CLK  input  1  single clock; FIFO read clock and output clock.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 DO  input  36  FIFO first-word-fall-through data; valid when EMPTY=0.
REQ-006 EMPTY  input  1  FIFO empty.
REQ-007 ALMOSTEMPTY  input  1  FIFO almost empty; 0 means at least BURST_LEN words are available.
REQ-008 RDEN  output  1  FIFO pop; combinational.
REQ-009 FLUSH  input  1  level request to drain the FIFO regardless of ALMOSTEMPTY.
REQ-010 OUT_DATA  output  36  registered output word.
REQ-011 OUT_VALID  output  1  OUT_DATA valid.
REQ-012 OUT_READY  input  1  sink accepts the word on a cycle where OUT_VALID&&OUT_READY.
REQ-013 OUT_LAST  output  1  qualifies the final word of a full burst.
REQ-014 FLUSH_DONE  output  1  one-cycle pulse when a flush completes.
REQ-015 UNDERRUN  output  1  sticky; EMPTY was seen mid-burst.

Function
REQ-016 States: IDLE, BURST, FLUSHING.
REQ-017 IDLE->BURST when EMPTY=0 and ALMOSTEMPTY=0; else IDLE->FLUSHING when FLUSH=1; BURST takes priority if both conditions hold.
REQ-018 Output register is free when OUT_VALID=0 or OUT_READY=1.
REQ-019 RDEN = (state is BURST or FLUSHING) && EMPTY=0 && output register free && RST=0.
REQ-020 On RDEN=1, the next edge loads OUT_DATA<=DO and sets OUT_VALID=1, giving 1-cycle latency from pop to valid.
REQ-021 If OUT_VALID&&OUT_READY with no pop, OUT_VALID clears next edge; OUT_DATA and OUT_LAST hold while OUT_VALID&&!OUT_READY.
REQ-022 Full throughput: one word per cycle while EMPTY=0 and OUT_READY=1.
REQ-023 Word counter (ceil(log2(BURST_LEN)) bits) increments per pop in BURST/FLUSHING and clears on entering either state.
REQ-024 The pop at count==BURST_LEN-1 loads OUT_LAST=1 and moves to IDLE; all other pops load OUT_LAST=0.
REQ-025 BURST with EMPTY=1: RDEN=0, stall in BURST, set UNDERRUN; resume popping when EMPTY=0.
REQ-026 FLUSHING with EMPTY=1 and output register free: go to IDLE and pulse FLUSH_DONE; the final flushed word carries no OUT_LAST unless REQ-024 applies.
REQ-027 FLUSH deassertion mid-flush has no effect; the flush runs to EMPTY.
REQ-028 A new burst can start the cycle after IDLE is re-entered; no dead cycles are mandated beyond that.

Reset
REQ-029 RST=1: state=IDLE, counter=0, OUT_VALID=0, OUT_LAST=0, OUT_DATA=0, FLUSH_DONE=0, UNDERRUN=0, RDEN=0 in the same cycle.
REQ-030 Reset mid-burst discards the word held in the output register; FIFO contents are not touched.

Structure
REQ-031 Shared package holds the WORD_W=36 constant, the BURST_LEN default and the state enum typedef.
REQ-032 Single module; no sub-module; the output register is inline.

Verification
REQ-033 FIFO pre-filled with 500 words 0..499, OUT_READY=1 -> 500 consecutive OUT_VALID cycles, data 0..499, OUT_LAST only on 499, UNDERRUN=0.
REQ-034 FIFO holds 10 words, ALMOSTEMPTY=1, FLUSH pulsed -> 10 words out, OUT_LAST never set, FLUSH_DONE pulses once, state IDLE.
REQ-035 Burst running, OUT_READY low for 5 cycles at word 100 -> RDEN=0 and OUT_DATA=100 held for 5 cycles, then sequence continues with no loss or duplicates.
REQ-036 EMPTY forced high for 3 cycles at word 200 of a burst -> RDEN=0, UNDERRUN=1 and stays 1, burst completes after refill with OUT_LAST on word 499.
REQ-037 RST asserted at word 50 -> next cycle OUT_VALID=0, UNDERRUN=0, IDLE; with ALMOSTEMPTY=0 a new burst starts from the FIFO head.
REQ-038 FLUSH=1 and ALMOSTEMPTY=0 together in IDLE -> BURST entered, exactly 500 words with OUT_LAST, then flush of the remainder.

Source files
------------

// File: rtl/fifo_burst_reader_pkg.sv
// Shared constants and state encoding for the FIFO burst reader.
// Imported by the top-level fifo_burst_reader.
package fifo_burst_reader_pkg;

  localparam int WORD_W            = 36;
  localparam int BURST_LEN_DEFAULT = 500;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BURST    = 2'd1,
    ST_FLUSHING = 2'd2
  } state_e;

  // Word counter width; never narrower than one bit.
  function automatic int cnt_width(input int len);
    return (len <= 2) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/fifo_burst_reader.sv
// Pops fixed-length bursts from a first-word-fall-through FIFO into a registered
// valid/ready output stage, with an on-demand flush path and a sticky underrun flag.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WORD_W-1:0] DO,
  input  logic              EMPTY,
  input  logic              ALMOSTEMPTY,
  output logic              RDEN,
  input  logic              FLUSH,
  output logic [WORD_W-1:0] OUT_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              OUT_LAST,
  output logic              FLUSH_DONE,
  output logic              UNDERRUN
);

  localparam int               CNT_W    = cnt_width(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              flush_done_q, flush_done_d;
  logic              underrun_q, underrun_d;

  logic out_free;
  logic active;
  logic pop;
  logic last_pop;

  always_comb begin
    out_free = !out_valid_q || OUT_READY;
    active   = (state_q == ST_BURST) || (state_q == ST_FLUSHING);
    pop      = active && !EMPTY && out_free && !RST;
    last_pop = pop && (cnt_q == LAST_CNT);

    state_d      = state_q;
    cnt_d        = cnt_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    flush_done_d = 1'b0;
    underrun_d   = underrun_q;

    // Data and LAST hold while the sink stalls; LAST drops with VALID.
    if (pop) begin
      out_data_d  = DO;
      out_valid_d = 1'b1;
      out_last_d  = last_pop;
    end else if (out_valid_q && OUT_READY) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (!EMPTY && !ALMOSTEMPTY) begin
          state_d = ST_BURST;
          cnt_d   = '0;
        end else if (FLUSH) begin
          state_d = ST_FLUSHING;
          cnt_d   = '0;
        end
      end

      ST_BURST: begin
        if (EMPTY) begin
          underrun_d = 1'b1;
        end
        if (pop) begin
          if (last_pop) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      // A flush longer than one burst keeps draining; the counter just wraps so
      // each full group of BURST_LEN words is still marked with LAST.
      ST_FLUSHING: begin
        if (pop) begin
          cnt_d = last_pop ? '0 : cnt_q + CNT_W'(1);
        end else if (EMPTY && out_free) begin
          state_d      = ST_IDLE;
          flush_done_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      flush_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      flush_done_q <= flush_done_d;
      underrun_q   <= underrun_d;
    end
  end

  assign RDEN       = pop;
  assign OUT_DATA   = out_data_q;
  assign OUT_VALID  = out_valid_q;
  assign OUT_LAST   = out_last_q;
  assign FLUSH_DONE = flush_done_q;
  assign UNDERRUN   = underrun_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: a FWFT FIFO model feeds the DUT and every
// accepted output word is logged, then compared against hand-derived sequences.
module tb_fifo_burst_reader;

  logic        CLK = 1'b0;
  logic        RST;
  logic [35:0] DO;
  logic        EMPTY;
  logic        ALMOSTEMPTY;
  logic        RDEN;
  logic        FLUSH;
  logic [35:0] OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        OUT_LAST;
  logic        FLUSH_DONE;
  logic        UNDERRUN;

  fifo_burst_reader #(.BURST_LEN(500)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .DO         (DO),
    .EMPTY      (EMPTY),
    .ALMOSTEMPTY(ALMOSTEMPTY),
    .RDEN       (RDEN),
    .FLUSH      (FLUSH),
    .OUT_DATA   (OUT_DATA),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .OUT_LAST   (OUT_LAST),
    .FLUSH_DONE (FLUSH_DONE),
    .UNDERRUN   (UNDERRUN)
  );

  always #5 CLK = ~CLK;

  // FWFT FIFO model; the read pointer advances with a non-blocking update so the
  // DUT samples the pre-pop head on the same edge.
  logic [35:0] mem [0:4095];
  logic [11:0] wrPtr = '0;
  logic [11:0] rdPtr = '0;
  logic [11:0] fifoCount;
  logic        forceEmpty;

  assign fifoCount   = wrPtr - rdPtr;
  assign DO          = mem[rdPtr];
  assign EMPTY       = (fifoCount == 12'd0) || forceEmpty;
  assign ALMOSTEMPTY = (fifoCount < 12'd500) || forceEmpty;

  always @(posedge CLK) begin
    if (RDEN) rdPtr <= rdPtr + 12'd1;
  end

  int          errCount   = 0;
  int          checkCount = 0;
  int          cycle      = 0;
  int          doneCount  = 0;
  logic [35:0] accData [$];
  logic        accLast [$];
  int          accCyc  [$];

  task automatic checkOutput(input string tag, input logic [35:0] actual, input logic [35:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, log any word the sink takes at the coming edge,
  // then return at the following falling edge.
  task automatic applyStimulus(input logic rst, input logic ready, input logic flush, input logic fe);
    RST        = rst;
    OUT_READY  = ready;
    FLUSH      = flush;
    forceEmpty = fe;
    if (OUT_VALID && OUT_READY && !RST) begin
      accData.push_back(OUT_DATA);
      accLast.push_back(OUT_LAST);
      accCyc.push_back(cycle);
    end
    if (FLUSH_DONE) doneCount++;
    @(posedge CLK);
    @(negedge CLK);
    cycle++;
  endtask

  task automatic pushWords(input int n, input logic [35:0] base);
    for (int i = 0; i < n; i++) mem[wrPtr + 12'(i)] = base + 36'(i);
    wrPtr = wrPtr + 12'(n);
  endtask

  task automatic clearLog();
    accData.delete();
    accLast.delete();
    accCyc.delete();
    doneCount = 0;
  endtask

  task automatic runUntil(input string tag, input int nWords, input int budget);
    int n = 0;
    while (accData.size() < nWords && n < budget) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      n++;
    end
    checkOutput({tag, "_count"}, 36'(accData.size()), 36'(nWords));
  endtask

  task automatic waitForWord(input string tag, input logic [35:0] value, input int budget);
    int n = 0;
    while (!(OUT_VALID && OUT_DATA == value) && n < budget) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      n++;
    end
    checkOutput({tag, "_reached"}, 36'(OUT_VALID && OUT_DATA == value), 36'd1);
  endtask

  task automatic checkBurst(input string tag, input int n, input logic [35:0] base, input int lastIdx);
    for (int i = 0; i < n && i < accData.size(); i++) begin
      checkOutput($sformatf("%s_data%0d", tag, i), accData[i], base + 36'(i));
      checkOutput($sformatf("%s_last%0d", tag, i), 36'(accLast[i]), (i == lastIdx) ? 36'd1 : 36'd0);
    end
  endtask

  initial begin
    RST        = 1'b1;
    OUT_READY  = 1'b1;
    FLUSH      = 1'b0;
    forceEmpty = 1'b0;
    @(negedge CLK);

    // Reset state
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_valid", 36'(OUT_VALID), 36'd0);
    checkOutput("rst_last", 36'(OUT_LAST), 36'd0);
    checkOutput("rst_data", OUT_DATA, 36'd0);
    checkOutput("rst_done", 36'(FLUSH_DONE), 36'd0);
    checkOutput("rst_underrun", 36'(UNDERRUN), 36'd0);
    pushWords(500, 36'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_rden", 36'(RDEN), 36'd0);

    // Full 500-word burst, sink always ready
    $display("[TB] full burst");
    clearLog();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t1_rden_first", 36'(RDEN), 36'd1);
    checkOutput("t1_valid_before_pop", 36'(OUT_VALID), 36'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t1_valid_latency", 36'(OUT_VALID), 36'd1);
    checkOutput("t1_first_data", OUT_DATA, 36'd0);
    runUntil("t1", 500, 600);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkBurst("t1", 500, 36'd0, 499);
    if (accCyc.size() == 500) checkOutput("t1_span", 36'(accCyc[499] - accCyc[0]), 36'd499);
    checkOutput("t1_underrun", 36'(UNDERRUN), 36'd0);
    checkOutput("t1_idle_valid", 36'(OUT_VALID), 36'd0);

    // Flush of a short FIFO below the almost-empty threshold
    $display("[TB] short flush");
    pushWords(10, 36'd1000);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t2_idle_rden", 36'(RDEN), 36'd0);
    checkOutput("t2_idle_valid", 36'(OUT_VALID), 36'd0);
    clearLog();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    runUntil("t2", 10, 40);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkBurst("t2", 10, 36'd1000, -1);
    checkOutput("t2_done_pulses", 36'(doneCount), 36'd1);
    checkOutput("t2_end_rden", 36'(RDEN), 36'd0);

    // Sink stall of five cycles at word 100
    $display("[TB] sink stall");
    clearLog();
    pushWords(500, 36'd2000);
    waitForWord("t3", 36'd2100, 600);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("t3_stall_rden%0d", i), 36'(RDEN), 36'd0);
      checkOutput($sformatf("t3_stall_valid%0d", i), 36'(OUT_VALID), 36'd1);
      checkOutput($sformatf("t3_stall_data%0d", i), OUT_DATA, 36'd2100);
    end
    runUntil("t3", 500, 700);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkBurst("t3", 500, 36'd2000, 499);
    checkOutput("t3_underrun", 36'(UNDERRUN), 36'd0);

    // FIFO empty for three cycles at word 200
    $display("[TB] mid-burst underrun");
    clearLog();
    pushWords(500, 36'd3000);
    waitForWord("t4", 36'd3200, 600);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput($sformatf("t4_empty_rden%0d", i), 36'(RDEN), 36'd0);
      checkOutput($sformatf("t4_underrun%0d", i), 36'(UNDERRUN), 36'd1);
    end
    runUntil("t4", 500, 700);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkBurst("t4", 500, 36'd3000, 499);
    checkOutput("t4_underrun_sticky", 36'(UNDERRUN), 36'd1);

    // Reset at word 50; the held word is lost and the next burst starts at 4051
    $display("[TB] reset mid-burst");
    clearLog();
    pushWords(600, 36'd4000);
    waitForWord("t5", 36'd4050, 600);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t5_rst_valid", 36'(OUT_VALID), 36'd0);
    checkOutput("t5_rst_underrun", 36'(UNDERRUN), 36'd0);
    checkOutput("t5_rst_rden", 36'(RDEN), 36'd0);
    checkOutput("t5_rst_last", 36'(OUT_LAST), 36'd0);
    checkOutput("t5_rst_data", OUT_DATA, 36'd0);
    clearLog();
    runUntil("t5", 500, 700);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkBurst("t5", 500, 36'd4051, 499);

    // Drain the 49 words left behind
    clearLog();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    runUntil("drain", 49, 100);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkBurst("drain", 49, 36'd4551, -1);
    checkOutput("drain_done_pulses", 36'(doneCount), 36'd1);

    // FLUSH and a full burst together: burst wins, then the remainder flushes
    $display("[TB] flush with full burst available");
    clearLog();
    pushWords(520, 36'd5000);
    begin
      int n = 0;
      while (accData.size() < 520 && n < 800) begin
        applyStimulus(1'b0, 1'b1, (accData.size() < 501), 1'b0);
        n++;
      end
    end
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t6_count", 36'(accData.size()), 36'd520);
    checkBurst("t6", 520, 36'd5000, 499);
    checkOutput("t6_done_pulses", 36'(doneCount), 36'd1);
    checkOutput("t6_end_rden", 36'(RDEN), 36'd0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
